// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle from uart_rx to the bridge core.
// Macro UART_RX_PARITY_EN adds the o_Parity_Err pulse.
interface uart_rx_if;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Busy;
  logic       o_Frame_Err;
`ifdef UART_RX_PARITY_EN
  logic       o_Parity_Err;

  modport master (
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Busy,
    output o_Frame_Err,
    output o_Parity_Err
  );

  modport slave (
    input o_Rx_DV,
    input o_Rx_Byte,
    input o_Rx_Busy,
    input o_Frame_Err,
    input o_Parity_Err
  );
`else
  modport master (
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Busy,
    output o_Frame_Err
  );

  modport slave (
    input o_Rx_DV,
    input o_Rx_Byte,
    input o_Rx_Busy,
    input o_Frame_Err
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, break lockout.
// Macro UART_RX_PARITY_EN adds a parity bit (sense set by PARITY_ODD).
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  input  logic      i_Rx_Serial,
  uart_rx_if.master rx_if
);

  localparam logic [15:0] C_BIT_END = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF    = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t      r_State;
  state_t      w_Next_State;

  logic        r_Rx_Meta;
  logic        r_Rx_Sync;
  logic [15:0] r_Count;
  logic [2:0]  r_Index;
  logic [7:0]  r_Shift;
  logic [7:0]  r_Rx_Byte;
  logic        r_Rx_DV;
  logic        r_Frame_Err;

  logic        w_Bit_End;
  logic        w_Cnt_Clr;
  logic        w_Shift_En;
  logic        w_Dv_Set;
  logic        w_Ferr_Set;
  logic        w_Par_Bad;

`ifdef UART_RX_PARITY_EN
  logic        r_Par_Bit;
  logic        r_Parity_Err;
  logic        w_Par_En;
  logic        w_Perr_Set;

  // Even sense: data XOR parity must be 0; odd sense: must be 1
  assign w_Par_Bad = ((^r_Shift) ^ r_Par_Bit) != PARITY_ODD;
`else
  // 8N1 build: parity never fails, the sense parameter has no effect
  assign w_Par_Bad = 1'b0 & PARITY_ODD;
`endif

  assign w_Bit_End = (r_Count == C_BIT_END);

  // Two-flop synchronizer on the asynchronous serial line
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Rx_Meta <= 1'b1;
      r_Rx_Sync <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx_Sync <= r_Rx_Meta;
    end
  end

  // State register
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_Next_State;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_Next_State = r_State;
    w_Cnt_Clr    = 1'b0;
    w_Shift_En   = 1'b0;
    w_Dv_Set     = 1'b0;
    w_Ferr_Set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_Par_En     = 1'b0;
    w_Perr_Set   = 1'b0;
`endif
    unique case (r_State)
      S_IDLE: begin
        w_Cnt_Clr = 1'b1;
        if (!r_Rx_Sync) begin
          w_Next_State = S_START;
        end
      end
      S_START: begin
        if (r_Count == C_HALF) begin
          w_Cnt_Clr    = 1'b1;
          w_Next_State = r_Rx_Sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_Bit_End) begin
          w_Cnt_Clr  = 1'b1;
          w_Shift_En = 1'b1;
          if (r_Index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_Next_State = S_PARITY;
`else
            w_Next_State = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_Bit_End) begin
          w_Cnt_Clr    = 1'b1;
          w_Par_En     = 1'b1;
          w_Next_State = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_Bit_End) begin
          w_Cnt_Clr = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_Perr_Set = w_Par_Bad;
`endif
          if (r_Rx_Sync) begin
            w_Dv_Set     = !w_Par_Bad;
            w_Next_State = S_IDLE;
          end else begin
            w_Ferr_Set   = 1'b1;
            w_Next_State = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_Cnt_Clr = 1'b1;
        if (r_Rx_Sync) begin
          w_Next_State = S_IDLE;
        end
      end
      default: begin
        w_Cnt_Clr    = 1'b1;
        w_Next_State = S_IDLE;
      end
    endcase
  end

  // Bit-period counter, bit index and data shift register
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Count <= 16'd0;
      r_Index <= 3'd0;
      r_Shift <= 8'h00;
    end else begin
      r_Count <= w_Cnt_Clr ? 16'd0 : r_Count + 16'd1;
      if (r_State == S_IDLE) begin
        r_Index <= 3'd0;
      end else if (w_Shift_En) begin
        r_Shift[r_Index] <= r_Rx_Sync;
        r_Index          <= r_Index + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Capture the parity bit and pulse the parity error at stop sample
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Par_Bit    <= 1'b0;
      r_Parity_Err <= 1'b0;
    end else begin
      if (w_Par_En) begin
        r_Par_Bit <= r_Rx_Sync;
      end
      r_Parity_Err <= w_Perr_Set;
    end
  end

  assign rx_if.o_Parity_Err = r_Parity_Err;
`endif

  // Output byte register and single-cycle result pulses
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Rx_Byte   <= 8'h00;
      r_Rx_DV     <= 1'b0;
      r_Frame_Err <= 1'b0;
    end else begin
      r_Rx_DV     <= w_Dv_Set;
      r_Frame_Err <= w_Ferr_Set;
      if (w_Dv_Set) begin
        r_Rx_Byte <= r_Shift;
      end
    end
  end

  assign rx_if.o_Rx_DV     = r_Rx_DV;
  assign rx_if.o_Rx_Byte   = r_Rx_Byte;
  assign rx_if.o_Frame_Err = r_Frame_Err;
  assign rx_if.o_Rx_Busy   = (r_State != S_IDLE);

  // Good byte and framing error can never be reported together
  a_pulse_excl: assert property (
    @(posedge i_Clock) disable iff (i_Reset)
    !(r_Rx_DV && r_Frame_Err));

  // Each result pulse lasts exactly one clock
  a_dv_one: assert property (
    @(posedge i_Clock) disable iff (i_Reset)
    r_Rx_DV |=> !r_Rx_DV);

  a_ferr_one: assert property (
    @(posedge i_Clock) disable iff (i_Reset)
    r_Frame_Err |=> !r_Frame_Err);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT=16.
// Define UART_RX_PARITY_EN to also exercise the parity build.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + 7 + 1 + 10 * CPB;
`else
  localparam int LAT = 2 + 7 + 1 + 9 * CPB;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_dv   = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int cyc    = 0;
  int t_dv   = 0;

  logic [7:0] scb_q[$];

  uart_rx_if rx_if();

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PODD)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_Serial(rx_line),
    .rx_if      (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.o_Rx_DV || rx_if.o_Frame_Err) begin
        chk("pulse_excl", 32'(rx_if.o_Rx_DV & rx_if.o_Frame_Err), 0);
      end
      if (rx_if.o_Rx_DV) begin
        n_dv++;
        t_dv = cyc;
        if (scb_q.size() == 0) begin
          chk("dv_unexpected", 1, 0);
        end else begin
          chk("rx_byte", 32'(rx_if.o_Rx_Byte), 32'(scb_q.pop_front()));
        end
      end
      if (rx_if.o_Frame_Err) n_ferr++;
`ifdef UART_RX_PARITY_EN
      if (rx_if.o_Parity_Err) begin
        n_perr++;
        chk("perr_no_dv", 32'(rx_if.o_Rx_DV), 0);
      end
`endif
    end
  end

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PODD);
`endif
    drive_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] d, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0;
    int fe0;
    int t0;
    int lat;
    int w;

    repeat (3) @(negedge clk);
    chk("rst_dv",   32'(rx_if.o_Rx_DV), 0);
    chk("rst_byte", 32'(rx_if.o_Rx_Byte), 0);
    chk("rst_busy", 32'(rx_if.o_Rx_Busy), 0);
    chk("rst_ferr", 32'(rx_if.o_Frame_Err), 0);
    rst = 1'b0;
    idle(2 * CPB);

    // Single byte with latency measurement
    t0 = cyc;
    scb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(CPB);
    lat = t_dv - t0 - 1;
    chk("a5_dv_cnt", 32'(n_dv), 1);
    chk("a5_ferr", 32'(n_ferr), 0);
    chk("a5_busy", 32'(rx_if.o_Rx_Busy), 0);
    chk("a5_latency_ok", 32'(lat >= LAT - 2 && lat <= LAT + 2), 1);

    // Back-to-back frames, no idle gap
    scb_q.push_back(8'h00);
    scb_q.push_back(8'hFF);
    scb_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(CPB);
    chk("b2b_dv_cnt", 32'(n_dv), 4);

    // Short low glitch must be rejected
    dv0 = n_dv;
    fe0 = n_ferr;
    rx_line = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_hi", 32'(rx_if.o_Rx_Busy), 1);
    rx_line = 1'b1;
    w = 0;
    while (rx_if.o_Rx_Busy && w < 9) begin
      @(negedge clk);
      w++;
    end
    chk("glitch_busy_drop", 32'(rx_if.o_Rx_Busy), 0);
    idle(2 * CPB);
    chk("glitch_no_dv", 32'(n_dv), 32'(dv0));
    chk("glitch_no_ferr", 32'(n_ferr), 32'(fe0));
    scb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(CPB);
    chk("glitch_next_dv", 32'(n_dv), 32'(dv0 + 1));

    // Framing error followed by a held-low break
    dv0 = n_dv;
    fe0 = n_ferr;
    send_frame(8'h81, 1'b0);
    repeat (40) @(negedge clk);
    chk("ferr_cnt", 32'(n_ferr), 32'(fe0 + 1));
    chk("ferr_no_dv", 32'(n_dv), 32'(dv0));
    chk("ferr_byte_kept", 32'(rx_if.o_Rx_Byte), 32'h5A);
    chk("break_busy", 32'(rx_if.o_Rx_Busy), 1);
    idle(2 * CPB);
    chk("break_exit_busy", 32'(rx_if.o_Rx_Busy), 0);
    chk("break_no_extra", 32'(n_ferr), 32'(fe0 + 1));
    scb_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(CPB);
    chk("ferr_next_dv", 32'(n_dv), 32'(dv0 + 1));

    // Reset in the middle of data bit 4 of 0xC3
    dv0 = n_dv;
    begin
      logic [7:0] d;
      d = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rx_line = d[4];
      repeat (CPB / 2) @(negedge clk);
    end
    chk("mid_busy", 32'(rx_if.o_Rx_Busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_byte", 32'(rx_if.o_Rx_Byte), 0);
    chk("mid_rst_busy", 32'(rx_if.o_Rx_Busy), 0);
    chk("mid_rst_dv", 32'(rx_if.o_Rx_DV), 0);
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3 * CPB);
    chk("mid_no_dv", 32'(n_dv), 32'(dv0));
    scb_q.push_back(8'h17);
    send_frame(8'h17, 1'b1);
    idle(CPB);
    chk("mid_next_dv", 32'(n_dv), 32'(dv0 + 1));

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, parity bit 1 is correct
    dv0 = n_dv;
    scb_q.push_back(8'h07);
    send_par(8'h07, 1'b1);
    idle(CPB);
    chk("par_ok_dv", 32'(n_dv), 32'(dv0 + 1));
    chk("par_ok_perr", 32'(n_perr), 0);
    send_par(8'h07, 1'b0);
    idle(CPB);
    chk("par_bad_perr", 32'(n_perr), 1);
    chk("par_bad_no_dv", 32'(n_dv), 32'(dv0 + 1));
    chk("par_bad_byte", 32'(rx_if.o_Rx_Byte), 32'h07);
`endif

    chk("scb_empty", 32'(scb_q.size()), 0);
    chk("final_ferr", 32'(n_ferr), 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the I2C-to-UART bridge. Converts an 8N1 serial stream on the RX pin into parallel bytes.
- Each received byte is presented as a one-cycle valid pulse to the bridge core, which forwards it toward the I2C side.
- Pairs with the bridge's UART transmitter and uses the same CLKS_PER_BIT convention: CLKS_PER_BIT = f(i_Clock) / baud, e.g. 10 MHz / 115200 = 87.

Parameters:
- CLKS_PER_BIT, 87, clocks per UART bit period; legal range 4..65535.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- o_Rx_DV  out  1  one-cycle pulse; o_Rx_Byte is valid and newly updated in that cycle.
- o_Rx_Byte  out  8  last good received byte; held stable between pulses.
- o_Rx_Busy  out  1  high from start-bit qualification until return to IDLE.
- o_Frame_Err  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (async assert, any state):
  - outputs: o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Busy=0, o_Frame_Err=0.
  - internals: state=IDLE, synchronizer flops=1, clock count=0, bit index=0.
  - Reset mid-frame discards the partial byte; no pulse is produced.
- Input sync: i_Rx_Serial passes through a 2-flop synchronizer. All decisions use the synced value (rx_s), giving 2 cycles of input latency.
- Clock counter: 16 bits; HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE:
  - count=0, index=0, Busy=0.
  - rx_s==0 -> START.
- START:
  - Busy=1; count up to HALF.
  - At count==HALF: rx_s==0 -> count=0, go to DATA. rx_s==1 -> glitch; return to IDLE with no outputs.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift[index], LSB first, and reset count.
  - index<7 -> index+1, stay in DATA. index==7 -> index=0, go to STOP (or PARITY if the macro is defined).
  - Each sample therefore lands mid-bit.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1 (and no parity error): o_Rx_Byte<=shift and o_Rx_DV=1 for one cycle, then IDLE.
  - rx_s==0: o_Frame_Err=1 for one cycle, o_Rx_Byte unchanged, go to BREAK.
- BREAK:
  - Busy=1; wait for rx_s==1, then IDLE.
  - This prevents a held-low line (break) from being re-read as continuous 0x00 frames.
- Pulse rules: o_Rx_DV and o_Frame_Err are never asserted in the same cycle. Each asserts for exactly one clock.
- Latency: for a line falling edge at cycle T, o_Rx_DV asserts at T + 2 + HALF + 1 + 9*CLKS_PER_BIT, within ±2 cycles.
- Re-arm: returning to IDLE at mid-stop-bit lets a back-to-back next start bit be detected with no lost frame.
- Sequencing guarantees:
  - A start edge during the final cycle of STOP is seen in IDLE on the next cycle.
  - Only one transition per clock.
  - Default/illegal state -> IDLE.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP.
  - PARITY counts CLKS_PER_BIT-1 and samples the parity bit.
  - Adds output o_Parity_Err (1 bit), which pulses at the stop-sample cycle if XOR(data, parity bit) != PARITY_ODD.
  - On a parity error o_Rx_DV is suppressed and o_Rx_Byte is unchanged. If the stop bit is also bad, o_Frame_Err pulses as well.
  - Frame length becomes 11 bits; latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state, no o_Parity_Err port; 8N1 only.

Test Plan:
- CLKS_PER_BIT=16, send 8N1 byte 0xA5 -> exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Frame_Err never high, Busy low after the pulse.
- Send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three DV pulses in order with bytes 0x00, 0xFF, 0x3C.
- Drive a 5-cycle low glitch (< HALF=7) -> no DV, no Frame_Err, Busy drops within 9 cycles, a following 0x5A is received correctly.
- Send 0x81 with the stop bit forced low, then hold low 40 cycles -> one Frame_Err pulse, no DV, o_Rx_Byte keeps its prior value, no further activity until the line goes high; next byte 0x42 is received.
- Assert i_Reset during data bit 4 of 0xC3 -> all outputs zero immediately; after release, 0x17 is received correctly.
- UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 1 -> DV with 0x07. Send 0x07 with parity bit 0 -> o_Parity_Err pulse, no DV.
